// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs and pipeline-control outputs shared between the
// pipeline datapath (master) and the stall/flush scheduler (slave).
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             ihit;
  logic             dhit;
  logic             dmem_req;
  logic             halt_wb;
  logic             idex_memread;
  logic [4:0]       idex_rd;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_rt_used;
  logic             branch_taken_ex;
  logic             jump_id;
  logic [1:0]       pipe_stall;
  logic             ifid_FLUSH;
  logic             idex_FLUSH;
  logic             pc_wen;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output ihit, dhit, dmem_req, halt_wb, idex_memread, idex_rd, ifid_rs, ifid_rt,
           ifid_rt_used, branch_taken_ex, jump_id,
    input  pipe_stall, ifid_FLUSH, idex_FLUSH, pc_wen, halted, mem_timeout,
           stall_cycles, flush_count
  );
  modport slave (
    input  ihit, dhit, dmem_req, halt_wb, idex_memread, idex_rd, ifid_rs, ifid_rt,
           ifid_rt_used, branch_taken_ex, jump_id,
    output pipe_stall, ifid_FLUSH, idex_FLUSH, pc_wen, halted, mem_timeout,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: prioritised stall/flush scheduler for the 5-stage pipeline with
// a data-wait watchdog and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input logic         CLK,
  input logic         nRST,
  hazard_ctrl_if.slave hif
);
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;
  localparam logic [1:0] NO_STALL   = 2'd0;
  localparam logic [1:0] IFID_STALL = 2'd1;
  localparam logic [1:0] IDEX_STALL = 2'd2;
  localparam logic [1:0] FULL_STALL = 2'd3;
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t           state, nxt;
  logic [WW-1:0]    wait_cnt;
  logic [1:0]       stall;
  logic             if_fl, id_fl, pcw, redirect, load_use;
  logic             halted_q, timeout_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  always_comb begin
    load_use = hif.idex_memread && hif.idex_rd != '0 &&
               (hif.idex_rd == hif.ifid_rs || (hif.ifid_rt_used && hif.idex_rd == hif.ifid_rt));
    nxt      = state;
    stall    = NO_STALL;
    if_fl    = 1'b0;
    id_fl    = 1'b0;
    pcw      = 1'b0;
    redirect = 1'b0;
    if (!nRST || state == HALT) stall = FULL_STALL;
    else if (hif.halt_wb) begin
      stall = FULL_STALL;
      nxt   = HALT;
    end else if ((state == DWAIT || hif.dmem_req) && !hif.dhit) begin
      stall = FULL_STALL;
      nxt   = DWAIT;
    end else begin
      nxt = RUN;
      if (hif.branch_taken_ex) begin
        if_fl    = 1'b1;
        id_fl    = 1'b1;
        pcw      = 1'b1;
        redirect = 1'b1;
      end else if (load_use) stall = IDEX_STALL;
      else if (hif.jump_id) begin
        // a jump redirects the PC even on a fetch miss; the stall bubbles IF/ID
        pcw   = 1'b1;
        if_fl = hif.ihit;
        stall = hif.ihit ? NO_STALL : IFID_STALL;
      end else if (!hif.ihit) stall = IFID_STALL;
      else pcw = 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state    <= nxt;
      halted_q <= nxt == HALT;
      wait_cnt <= (state == DWAIT && nxt == DWAIT) ?
                  (wait_cnt == WW'(TIMEOUT - 1) ? wait_cnt : wait_cnt + WW'(1)) : '0;
      if (state == DWAIT && nxt == DWAIT && wait_cnt == WW'(TIMEOUT - 1)) timeout_q <= 1'b1;
      if (stall != NO_STALL && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (redirect && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end
  assign hif.pipe_stall   = stall;
  assign hif.ifid_FLUSH   = if_fl;
  assign hif.idex_FLUSH   = id_fl;
  assign hif.pc_wen       = pcw;
  assign hif.halted       = halted_q;
  assign hif.mem_timeout  = timeout_q;
  assign hif.stall_cycles = stall_q;
  assign hif.flush_count  = flush_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized checks of hazard_ctrl against a
// cycle-level reference model of the priority rules, watchdog and counters.
module tb_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 6;
  localparam int CMAX    = (1 << CNT_W) - 1;
  logic CLK = 1'b0;
  logic nRST;
  int   n_cmp = 0;
  int   n_err = 0;
  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (.CLK(CLK), .nRST(nRST), .hif(hif));
  always #5 CLK = ~CLK;
  bit m_halt, m_dwait, m_to;
  int m_wait, m_stall, m_flush;
  int e_ps;
  bit e_if, e_id, e_pc, e_br, g_halt, g_dwait;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic void m_reset();
    m_halt = 0; m_dwait = 0; m_to = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endfunction
  function automatic void model_out();
    bit lu;
    lu = hif.idex_memread && hif.idex_rd != 0 &&
         (hif.idex_rd == hif.ifid_rs || (hif.ifid_rt_used && hif.idex_rd == hif.ifid_rt));
    e_ps = 0; e_if = 0; e_id = 0; e_pc = 0; e_br = 0;
    g_halt = m_halt; g_dwait = 0;
    if (!nRST || m_halt) e_ps = 3;
    else if (hif.halt_wb) begin e_ps = 3; g_halt = 1; end
    else if ((hif.dmem_req || m_dwait) && !hif.dhit) begin e_ps = 3; g_dwait = 1; end
    else if (hif.branch_taken_ex) begin e_if = 1; e_id = 1; e_pc = 1; e_br = 1; end
    else if (lu) e_ps = 2;
    else if (hif.jump_id) begin e_pc = 1; e_if = hif.ihit; e_ps = hif.ihit ? 0 : 1; end
    else if (!hif.ihit) e_ps = 1;
    else e_pc = 1;
  endfunction
  function automatic void model_seq();
    if (!nRST) begin m_reset(); return; end
    m_stall = (e_ps != 0 && m_stall < CMAX) ? m_stall + 1 : m_stall;
    m_flush = (e_br && m_flush < CMAX) ? m_flush + 1 : m_flush;
    if (m_dwait && g_dwait) begin
      m_to = m_to | (m_wait >= TIMEOUT - 1);
      m_wait++;
    end else m_wait = 0;
    m_dwait = g_dwait;
    m_halt  = g_halt;
  endfunction
  task automatic tick();
    @(negedge CLK);
    model_out();
    chk("pipe_stall", hif.pipe_stall, e_ps);
    chk("ifid_FLUSH", hif.ifid_FLUSH, e_if);
    chk("idex_FLUSH", hif.idex_FLUSH, e_id);
    chk("pc_wen", hif.pc_wen, e_pc);
    chk("halted", hif.halted, m_halt);
    chk("mem_timeout", hif.mem_timeout, m_to);
    chk("stall_cycles", hif.stall_cycles, m_stall);
    chk("flush_count", hif.flush_count, m_flush);
    @(posedge CLK);
    model_seq();
    #1;
  endtask
  task automatic idle();
    hif.ihit = 1; hif.dhit = 0; hif.dmem_req = 0; hif.halt_wb = 0;
    hif.idex_memread = 0; hif.idex_rd = 0; hif.ifid_rs = 0; hif.ifid_rt = 0;
    hif.ifid_rt_used = 0; hif.branch_taken_ex = 0; hif.jump_id = 0;
  endtask
  task automatic do_reset();
    nRST = 0;
    m_reset();
    tick();
    tick();
    nRST = 1;
  endtask
  initial begin
    idle();
    nRST = 0;
    m_reset();
    #1;
    do_reset();
    chk("rst_halted", hif.halted, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("sl_stall", hif.stall_cycles, 0);
    hif.idex_memread = 1; hif.idex_rd = 5; hif.ifid_rs = 5;
    tick();
    hif.idex_memread = 0;
    tick();
    chk("lu_stall", hif.stall_cycles, 1);
    hif.dmem_req = 1;
    for (int i = 0; i < 3; i++) tick();
    hif.dhit = 1;
    tick();
    idle();
    chk("dw_stall", hif.stall_cycles, 4);
    chk("dw_noto", hif.mem_timeout, 0);
    hif.dmem_req = 1;
    for (int i = 0; i < 6; i++) tick();
    chk("to_set", hif.mem_timeout, 1);
    hif.dhit = 1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    chk("to_sticky", hif.mem_timeout, 1);
    do_reset();
    chk("rst_to", hif.mem_timeout, 0);
    hif.ihit = 0; hif.branch_taken_ex = 1;
    tick();
    chk("br_flush", hif.flush_count, 1);
    hif.dmem_req = 1;
    tick();
    chk("br_dmiss", hif.flush_count, 1);
    hif.dhit = 1;
    tick();
    chk("br_replay", hif.flush_count, 2);
    idle();
    hif.ihit = 0; hif.jump_id = 1;
    tick();
    hif.ihit = 1;
    tick();
    idle();
    hif.halt_wb = 1;
    tick();
    hif.halt_wb = 0; hif.branch_taken_ex = 1; hif.jump_id = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("hlt_halted", hif.halted, 1);
    chk("hlt_flush", hif.flush_count, 2);
    idle();
    do_reset();
    chk("hlt_rst", hif.halted, 0);
    chk("hlt_rst_cnt", hif.stall_cycles, 0);
    hif.halt_wb = 1;
    tick();
    hif.halt_wb = 0;
    for (int i = 0; i < 70; i++) tick();
    chk("sat_stall", hif.stall_cycles, CMAX);
    do_reset();
    hif.branch_taken_ex = 1;
    for (int i = 0; i < 70; i++) tick();
    chk("sat_flush", hif.flush_count, CMAX);
    idle();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      nRST = ($urandom % 100) != 0;
      if (!nRST) m_reset();
      hif.ihit = ($urandom % 4) != 0;
      hif.dhit = ($urandom % 3) == 0;
      hif.dmem_req = ($urandom % 3) == 0;
      hif.halt_wb = ($urandom % 80) == 0;
      hif.idex_memread = $urandom % 2;
      hif.idex_rd = 5'($urandom % 4);
      hif.ifid_rs = 5'($urandom % 4);
      hif.ifid_rt = 5'($urandom % 4);
      hif.ifid_rt_used = $urandom % 2;
      hif.branch_taken_ex = ($urandom % 6) == 0;
      hif.jump_id = ($urandom % 6) == 0;
      tick();
    end
    nRST = 1;
    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/flush scheduler for the 5-stage pipeline register bank.
- Each cycle, arbitrates between these events and drives the pipeline register bank's pipe_stall, ifid_FLUSH and idex_FLUSH controls plus the PC write enable:
  - instruction-fetch misses
  - data-memory misses
  - load-use hazards
  - control redirects
  - halt
- Also tracks memory-wait time (watchdog) and stall/flush performance counters.

Parameters:
TIMEOUT, 1024, consecutive DWAIT cycles before mem_timeout is set
CNT_W, 32, width of performance counters

Ports:
CLK  in  1  clock
nRST  in  1  reset; asynchronous, active-low
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dmem_req  in  1  MEM stage holds a load or store
halt_wb  in  1  HALT instruction in WB
idex_memread  in  1  EX stage holds a load
idex_rd  in  5  EX stage destination register
ifid_rs  in  5  ID stage source register 1
ifid_rt  in  5  ID stage source register 2
ifid_rt_used  in  1  ID instruction reads rt
branch_taken_ex  in  1  branch/jr resolved taken in EX
jump_id  in  1  direct jump decoded in ID
pipe_stall  out  2  0=NO_STALL, 1=IFID_STALL, 2=IDEX_STALL, 3=FULL_STALL
ifid_FLUSH  out  1  zero IF/ID on advance
idex_FLUSH  out  1  zero ID/EX on advance
pc_wen  out  1  PC register update enable
halted  out  1  core halted (registered)
mem_timeout  out  1  sticky data-wait watchdog flag (registered)
stall_cycles  out  CNT_W  cycles with pipe_stall != NO_STALL
flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- FSM states: RUN, DWAIT, HALT.
- Reset:
  - state=RUN, halted=0, mem_timeout=0, counters=0, wait_cnt=0.
  - While nRST low: pipe_stall=FULL_STALL, flushes=0, pc_wen=0.
- Control outputs are combinational from state + inputs (same-cycle response to hits). halted, mem_timeout and counters are registered.
- load_use = idex_memread & idex_rd!=0 & (idex_rd==ifid_rs | (ifid_rt_used & idex_rd==ifid_rt)).
- Outputs by priority; first match wins, unlisted outputs are 0:
  1. state==HALT: FULL_STALL, pc_wen=0.
  2. halt_wb: FULL_STALL, pc_wen=0; next state HALT.
  3. dmem_req & !dhit: FULL_STALL, pc_wen=0; next state DWAIT.
  4. branch_taken_ex: NO_STALL, ifid_FLUSH=1, idex_FLUSH=1, pc_wen=1 (redirect regardless of ihit); flush_count++.
  5. load_use: IDEX_STALL, pc_wen=0.
  6. jump_id & ihit: NO_STALL, ifid_FLUSH=1, pc_wen=1.
  7. jump_id & !ihit: IFID_STALL, pc_wen=1 (redirect aborts fetch; IF/ID bubbled by stall).
  8. !ihit: IFID_STALL, pc_wen=0.
  9. otherwise: NO_STALL, pc_wen=1.
- Simultaneous events:
  - dmiss dominates branch/load-use/imiss; frozen EX re-presents the branch after dhit.
  - Branch in EX and load-use are mutually exclusive by construction. Branch still wins if both are asserted.
- DWAIT:
  - On entry, wait_cnt counts cycles in DWAIT.
  - dhit returns to RUN, and outputs that cycle follow priorities 4-9.
  - wait_cnt clears on RUN.
  - If wait_cnt reaches TIMEOUT-1 while still in DWAIT, mem_timeout=1, sticky until reset. The pipeline keeps stalling.
- HALT: absorbing until reset. halted=1 from the cycle after halt_wb.
- stall_cycles increments each cycle pipe_stall!=NO_STALL (outside reset).
- stall_cycles and flush_count both saturate at all-ones.
- Reset mid-DWAIT or mid-HALT: immediate return to reset values.

Test Plan:
- Straight-line, ihit=1 always, no hazards, 10 cycles -> pipe_stall=NO_STALL, pc_wen=1 every cycle, stall_cycles=0.
- idex_memread=1, idex_rd=5, ifid_rs=5 for 1 cycle -> IDEX_STALL, pc_wen=0 that cycle; next cycle (memread=0) NO_STALL; stall_cycles=1.
- dmem_req=1, dhit low 3 cycles then high -> FULL_STALL for 3 cycles, state DWAIT, then NO_STALL on dhit cycle; stall_cycles=3. Repeat with TIMEOUT=4 and dhit held low 6 cycles -> mem_timeout rises after 4th DWAIT cycle and stays 1.
- branch_taken_ex=1 with ihit=0 -> NO_STALL, both flushes=1, pc_wen=1, flush_count=1. Same with dmem_req=1, dhit=0 -> FULL_STALL, no flush, flush_count unchanged.
- halt_wb pulse -> FULL_STALL that cycle; halted=1 next cycle; stays FULL_STALL/pc_wen=0 despite ihit/branch inputs. nRST low -> halted=0, counters=0.
- jump_id=1, ihit=0 -> IFID_STALL, pc_wen=1, ifid_FLUSH=0. jump_id=1, ihit=1 -> NO_STALL, ifid_FLUSH=1, idex_FLUSH=0.
